// File: rtl/seat_assigner.sv
// seat_assigner: allocation stage in front of the seat table memory.
// Takes one student-number request at a time, finds a free seat with a
// round-robin scan of an occupancy bitmap, writes the seat table for one
// cycle, then pulses a result back to the requester. Seat releases are
// accepted in any state.
//
// Optional feature macro: SEAT_DUP_CHECK_EN
//   defined   - shadow table of seated students; a repeat request for a
//               seated student is rejected with resp_dup.
//   undefined - no shadow table; resp_dup stays 0. Latency is identical.
//
// Ports:
//   clk_seat, rst_n_seat           clock (rising edge), async active-low reset
//   req_valid/req_student/req_ready allocation request handshake
//   rel_valid/rel_seat             seat release strobe and seat number
//   write_mem1/Student_No_mem1/Seat_No_mem1  seat table write port
//   resp_valid/resp_seat/resp_full/resp_dup  one-cycle result
//   free_count                     number of unoccupied seats
module seat_assigner #(
  parameter int unsigned NUM_SEATS = 32
) (
  input  logic        clk_seat,
  input  logic        rst_n_seat,
  input  logic        req_valid,
  input  logic [24:0] req_student,
  output logic        req_ready,
  input  logic        rel_valid,
  input  logic [7:0]  rel_seat,
  output logic        write_mem1,
  output logic [24:0] Student_No_mem1,
  output logic [7:0]  Seat_No_mem1,
  output logic        resp_valid,
  output logic [7:0]  resp_seat,
  output logic        resp_full,
  output logic        resp_dup,
  output logic [5:0]  free_count
);

  localparam int unsigned IW = (NUM_SEATS > 1) ? $clog2(NUM_SEATS) : 1;
  localparam int unsigned SW = 25;

  typedef enum logic [2:0] {IDLE, CHECK, SCAN, WRITE, RESP} state_t;

  state_t          state, next_state;
  logic [NUM_SEATS-1:0] occ;
  logic [IW-1:0]   ptr, scan_idx, next_scan_idx;
  logic [SW-1:0]   student;
  logic            dup_hit, rel_hit, alloc;
  logic            next_full, next_dup;

  // Seat index advance modulo NUM_SEATS.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == IW'(NUM_SEATS - 1)) ? '0 : i + IW'(1);
  endfunction

  // A release only counts when it names an in-range occupied seat.
  assign rel_hit = rel_valid && (rel_seat < 8'(NUM_SEATS)) && occ[rel_seat[IW-1:0]];
  assign alloc   = (state == WRITE);

`ifdef SEAT_DUP_CHECK_EN
  logic [SW-1:0] shadow [NUM_SEATS];

  // Shadow entries are only meaningful while their occupancy bit is set.
  always_ff @(posedge clk_seat) begin
    if (alloc) shadow[scan_idx] <= student;
  end

  // Parallel compare of the captured student against all seated students.
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < int'(NUM_SEATS); i++) begin
      if (occ[i] && (shadow[i] == student)) dup_hit = 1'b1;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_seat or negedge rst_n_seat) begin
    if (!rst_n_seat) state <= IDLE;
    else             state <= next_state;
  end

  // Next-state and scan control.
  always_comb begin
    next_state    = state;
    next_scan_idx = scan_idx;
    next_full     = 1'b0;
    next_dup      = 1'b0;
    case (state)
      IDLE:  if (req_valid) next_state = CHECK;
      CHECK: begin
        if (dup_hit) begin
          next_state = RESP;
          next_dup   = 1'b1;
        end else if (free_count == 6'd0) begin
          next_state = RESP;
          next_full  = 1'b1;
        end else begin
          next_state    = SCAN;
          next_scan_idx = ptr;
        end
      end
      // Terminates within NUM_SEATS cycles because CHECK saw a free seat.
      SCAN: begin
        if (!occ[scan_idx]) next_state = WRITE;
        else                next_scan_idx = wrap_inc(scan_idx);
      end
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath, occupancy bookkeeping and registered outputs.
  always_ff @(posedge clk_seat or negedge rst_n_seat) begin
    if (!rst_n_seat) begin
      occ             <= '0;
      ptr             <= '0;
      scan_idx        <= '0;
      student         <= '0;
      free_count      <= 6'(NUM_SEATS);
      req_ready       <= 1'b1;
      write_mem1      <= 1'b0;
      Student_No_mem1 <= '0;
      Seat_No_mem1    <= '0;
      resp_valid      <= 1'b0;
      resp_seat       <= '0;
      resp_full       <= 1'b0;
      resp_dup        <= 1'b0;
    end else begin
      scan_idx <= next_scan_idx;
      if (state == IDLE && req_valid) student <= req_student;

      // rel_hit and alloc never target the same seat: the seat being
      // written still has its bit clear, so its release is ignored.
      if (rel_hit) occ[rel_seat[IW-1:0]] <= 1'b0;
      if (alloc) begin
        occ[scan_idx] <= 1'b1;
        ptr           <= wrap_inc(scan_idx);
      end
      free_count <= free_count + 6'(rel_hit) - 6'(alloc);

      req_ready       <= (next_state == IDLE);
      write_mem1      <= (next_state == WRITE);
      Student_No_mem1 <= (next_state == WRITE) ? student : '0;
      Seat_No_mem1    <= (next_state == WRITE) ? 8'(next_scan_idx) : '0;
      resp_valid      <= (next_state == RESP);
      resp_seat       <= (next_state == RESP && state == WRITE) ? 8'(scan_idx) : '0;
      resp_full       <= next_full;
      resp_dup        <= next_dup;
    end
  end

endmodule
